// File: rtl/fadd40_norm_round.sv
// Normalize-and-round stage of the 40-bit floating-point adder.
// Stage 1 aligns the raw magnitude using the leading-zero count and adjusts the exponent.
// Stage 2 rounds to nearest-even, handles zero/underflow/overflow and packs the result.
module fadd40_norm_round #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 31,
    parameter int unsigned EXT_W  = 8,
    parameter int unsigned LZD_W  = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_sign,
    input  logic [EXP_W-1:0]          i_exp,
    input  logic [FRAC_W+EXT_W+1:0]   i_mant,
    input  logic [LZD_W-1:0]          i_lzd_num,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [EXP_W+FRAC_W:0]     o_result,
    output logic                      o_zero,
    output logic                      o_ovf,
    output logic                      o_unf
);

    localparam int unsigned MANT_W = FRAC_W + EXT_W + 2;
    // Signed working exponent: room for +1 carry and negative results.
    localparam int unsigned EW     = EXP_W + 2;
    // Bits below the hidden one; the leading one is implicit once aligned.
    localparam int unsigned LOW_W  = MANT_W - 2;
    localparam int unsigned FW1    = FRAC_W + 1;
    localparam int unsigned RES_W  = EXP_W + FRAC_W + 1;

    // Handshake
    logic s1_valid_q, s2_valid_q;
    logic s1_load, s2_load;

    assign s2_load = ~s2_valid_q | i_ready;
    assign s1_load = ~s1_valid_q | s2_load;
    assign o_ready = s1_load;

    // Stage 1 combinational: shift and exponent adjust
    logic [LZD_W-1:0] lz;
    logic [LZD_W-1:0] lz_m1;
    logic [EW-1:0]    exp_ext;
    logic [EW-1:0]    s1_exp_d;
    logic [LOW_W-1:0] s1_frac_d;
    logic             s1_sticky_d;
    logic             s1_zero_d;
    logic             s1_unf_d;

    // Align leading one to the hidden-bit position and track the exponent change.
    always_comb begin
        lz          = (i_lzd_num > LZD_W'(MANT_W - 1)) ? LZD_W'(MANT_W - 1) : i_lzd_num;
        lz_m1       = lz - LZD_W'(1);
        exp_ext     = {2'b00, i_exp};
        s1_exp_d    = exp_ext;
        s1_frac_d   = LOW_W'(i_mant);
        s1_sticky_d = 1'b0;
        if (lz == '0) begin
            // Carry out of the adder: shift right, keep the dropped bit as sticky.
            s1_frac_d   = LOW_W'(i_mant >> 1);
            s1_exp_d    = exp_ext + EW'(1);
            s1_sticky_d = i_mant[0];
        end else if (lz != LZD_W'(1)) begin
            s1_frac_d = LOW_W'(i_mant << lz_m1);
            s1_exp_d  = exp_ext - EW'(lz_m1);
        end
        s1_zero_d = (i_mant == '0);
        s1_unf_d  = s1_exp_d[EW-1] | (s1_exp_d == '0);
    end

    // Stage 1 registers
    logic             s1_sign_q;
    logic [EW-1:0]    s1_exp_q;
    logic [LOW_W-1:0] s1_frac_q;
    logic             s1_sticky_q;
    logic             s1_zero_q;
    logic             s1_unf_q;

    // Stage 1 pipeline register; accepts new data whenever it can hand its contents on.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
            s1_sticky_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_unf_q    <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_sign_q   <= i_sign;
                s1_exp_q    <= s1_exp_d;
                s1_frac_q   <= s1_frac_d;
                s1_sticky_q <= s1_sticky_d;
                s1_zero_q   <= s1_zero_d;
                s1_unf_q    <= s1_unf_d;
            end
        end
    end

    // Stage 2 combinational: round to nearest-even and pack
    logic [FRAC_W-1:0] frac_trunc;
    logic              lsb_bit, guard_bit, round_bit, sticky_bit, round_up;
    logic [FW1-1:0]    frac_inc;
    logic [EW-1:0]     exp_fin;
    logic              ovf_c;
    logic [RES_W-1:0]  s2_result_d;
    logic              s2_zero_d, s2_ovf_d, s2_unf_d;

    // Round, then resolve special cases with priority zero > underflow > overflow.
    always_comb begin
        frac_trunc = s1_frac_q[LOW_W-1:EXT_W];
        lsb_bit    = s1_frac_q[EXT_W];
        guard_bit  = s1_frac_q[EXT_W-1];
        round_bit  = s1_frac_q[EXT_W-2];
        sticky_bit = (|s1_frac_q[EXT_W-3:0]) | s1_sticky_q;
        round_up   = guard_bit & (round_bit | sticky_bit | lsb_bit);
        // A carry into bit FRAC_W means 1.11..1 rounded to 2.0: fraction wraps to zero.
        frac_inc   = {1'b0, frac_trunc} + FW1'(round_up);
        exp_fin    = s1_exp_q + EW'(frac_inc[FRAC_W]);
        ovf_c      = (exp_fin >= {2'b00, {EXP_W{1'b1}}});

        s2_result_d = {s1_sign_q, exp_fin[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
        s2_zero_d   = 1'b0;
        s2_ovf_d    = 1'b0;
        s2_unf_d    = 1'b0;
        if (s1_zero_q) begin
            s2_result_d = '0;
            s2_zero_d   = 1'b1;
        end else if (s1_unf_q) begin
            s2_result_d = {s1_sign_q, {(RES_W-1){1'b0}}};
            s2_unf_d    = 1'b1;
        end else if (ovf_c) begin
            s2_result_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            s2_ovf_d    = 1'b1;
        end
    end

    // Stage 2 output register; holds while downstream stalls.
    logic [RES_W-1:0] s2_result_q;
    logic             s2_zero_q, s2_ovf_q, s2_unf_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_zero_q   <= s2_zero_d;
                s2_ovf_q    <= s2_ovf_d;
                s2_unf_q    <= s2_unf_d;
            end
        end
    end

    assign o_valid  = s2_valid_q;
    assign o_result = s2_result_q;
    assign o_zero   = s2_zero_q;
    assign o_ovf    = s2_ovf_q;
    assign o_unf    = s2_unf_q;

endmodule

// File: tb/tb_fadd40_norm_round.sv
// Directed testbench for fadd40_norm_round with hand-computed expected results.
module tb_fadd40_norm_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready_o;
    logic        sign;
    logic [7:0]  expo;
    logic [40:0] mant;
    logic [5:0]  lzd;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] result;
    logic        zero_f, ovf_f, unf_f;

    int checks = 0;
    int errors = 0;

    fadd40_norm_round dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (in_valid),
        .o_ready   (in_ready_o),
        .i_sign    (sign),
        .i_exp     (expo),
        .i_mant    (mant),
        .i_lzd_num (lzd),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_result  (result),
        .o_zero    (zero_f),
        .o_ovf     (ovf_f),
        .o_unf     (unf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One isolated transaction: drive, wait the 2-cycle latency, check result and flags.
    task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                           input logic [40:0] m, input logic [5:0] l,
                           input logic [39:0] exp_res, input logic [2:0] exp_flags);
        sign     = s;
        expo     = e;
        mant     = m;
        lzd      = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_res"}, 64'(result), 64'(exp_res));
        chk({tag, "_flags"}, 64'({zero_f, ovf_f, unf_f}), 64'(exp_flags));
    endtask

    localparam logic [40:0] BASE_M = 41'h080_0000_0000;
    localparam logic [39:0] BASE_R = 40'h32_0000_0000;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sign      = 1'b0;
        expo      = 8'd0;
        mant      = '0;
        lzd       = '0;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_res", 64'(result), 64'(40'h0));
        chk("rst_flags", 64'({zero_f, ovf_f, unf_f}), 64'(3'b000));
        chk("rst_ready", 64'(in_ready_o), 64'(1'b1));
        rst_n = 1'b1;
        tick();

        // Flag order in expectations: {zero, ovf, unf}
        run_one("plain", 1'b0, 8'd100, 41'h080_0000_0000, 6'd1, 40'h32_0000_0000, 3'b000);
        run_one("carry", 1'b0, 8'd100, 41'h180_0000_0000, 6'd0, 40'h32_C000_0000, 3'b000);
        run_one("cancel", 1'b0, 8'd100, 41'h000_0000_0100, 6'd32, 40'h22_8000_0000, 3'b000);
        run_one("unf_edge_ok", 1'b0, 8'd32, 41'h000_0000_0100, 6'd32, 40'h00_8000_0000, 3'b000);
        run_one("unf", 1'b0, 8'd31, 41'h000_0000_0100, 6'd32, 40'h00_0000_0000, 3'b001);
        run_one("unf_neg", 1'b1, 8'd31, 41'h000_0000_0100, 6'd32, 40'h80_0000_0000, 3'b001);
        run_one("rne_odd", 1'b0, 8'd100, 41'h080_0000_0180, 6'd1, 40'h32_0000_0002, 3'b000);
        run_one("rne_even", 1'b0, 8'd100, 41'h080_0000_0080, 6'd1, 40'h32_0000_0000, 3'b000);
        run_one("rnd_ovf", 1'b0, 8'd254, 41'h0FF_FFFF_FF80, 6'd1, 40'h7F_8000_0000, 3'b010);
        run_one("carry_ovf", 1'b1, 8'd254, 41'h100_0000_0000, 6'd0, 40'hFF_8000_0000, 3'b010);
        run_one("zero", 1'b1, 8'd77, 41'h0, 6'd5, 40'h00_0000_0000, 3'b100);
        // Sticky from the bit dropped by the carry right-shift breaks the tie.
        run_one("rsh_sticky", 1'b0, 8'd100, 41'h100_0000_0101, 6'd0, 40'h32_8000_0001, 3'b000);
        run_one("rsh_tie", 1'b0, 8'd100, 41'h100_0000_0100, 6'd0, 40'h32_8000_0000, 3'b000);
        run_one("lzd40", 1'b0, 8'd100, 41'h000_0000_0001, 6'd40, 40'h1E_8000_0000, 3'b000);
        run_one("lzd63", 1'b0, 8'd100, 41'h000_0000_0001, 6'd63, 40'h1E_8000_0000, 3'b000);

        // Streaming: 4 back-to-back inputs produce 4 consecutive beats in order.
        tick();
        sign = 1'b0;
        expo = 8'd100;
        lzd  = 6'd1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            mant     = BASE_M | (41'(i) << 8);
            if (i < 4) chk($sformatf("stream_ready%0d", i), 64'(in_ready_o), 64'(1'b1));
            tick();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("stream_v%0d", i), 64'(out_valid), 64'(1'b1));
                chk($sformatf("stream_r%0d", i), 64'(result), 64'(BASE_R + 40'(i - 1)));
            end else if (i == 5) begin
                chk("stream_drain", 64'(out_valid), 64'(1'b0));
            end
        end

        // Backpressure: both stages fill, output holds, nothing lost or repeated.
        in_valid = 1'b1;
        mant     = BASE_M | (41'd10 << 8);
        tick();
        out_ready = 1'b0;
        mant      = BASE_M | (41'd11 << 8);
        tick();
        chk("stall_v0", 64'(out_valid), 64'(1'b1));
        chk("stall_r0", 64'(result), 64'(BASE_R + 40'd10));
        chk("stall_rdy0", 64'(in_ready_o), 64'(1'b0));
        mant = BASE_M | (41'd12 << 8);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk($sformatf("stall_r%0d", i), 64'(result), 64'(BASE_R + 40'd10));
            chk($sformatf("stall_rdy%0d", i), 64'(in_ready_o), 64'(1'b0));
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_rdy", 64'(in_ready_o), 64'(1'b1));
        tick();
        in_valid = 1'b0;
        chk("unstall_r11", 64'(result), 64'(BASE_R + 40'd11));
        tick();
        chk("unstall_v12", 64'(out_valid), 64'(1'b1));
        chk("unstall_r12", 64'(result), 64'(BASE_R + 40'd12));
        tick();
        chk("unstall_drain", 64'(out_valid), 64'(1'b0));

        // Reset mid-stream discards in-flight data.
        in_valid = 1'b1;
        mant     = BASE_M | (41'd20 << 8);
        tick();
        mant = BASE_M | (41'd21 << 8);
        tick();
        chk("pre_rst_v", 64'(out_valid), 64'(1'b1));
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("mid_rst_v", 64'(out_valid), 64'(1'b0));
        chk("mid_rst_r", 64'(result), 64'(40'h0));
        rst_n = 1'b1;
        tick();
        chk("post_rst_v", 64'(out_valid), 64'(1'b0));
        tick();
        chk("post_rst_v2", 64'(out_valid), 64'(1'b0));
        run_one("restart", 1'b0, 8'd100, 41'h180_0000_0000, 6'd0, 40'h32_C000_0000, 3'b000);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
